// File: rtl/mdu_iter_pkg.sv
// -----------------------------------------------------------------------------
// mdu_iter_pkg
// Shared CPU package for the iterative multiply/divide unit: datapath width,
// iteration count, the MULT/MULTU/DIV/DIVU op encoding, the controller state
// encoding and two small op-decoding helpers.
// -----------------------------------------------------------------------------
package mdu_iter_pkg;

  localparam int MDU_W     = 32;                  // operand and result width
  localparam int MDU_ITERS = 32;                  // radix-2 steps per operation
  localparam int MDU_CNT_W = $clog2(MDU_ITERS);   // iteration counter width

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// -----------------------------------------------------------------------------
// mdu_step
// One radix-2 iteration of the MDU datapath, purely combinational.
//   Multiply (shift-add, LSB first): {acc, x} holds the partial product with
//     the unconsumed multiplier bits in x; add the multiplicand when x[0]=1,
//     then shift the 2W-bit pair right by one.
//   Divide (restoring shift-subtract): acc is the partial remainder, x holds
//     the unconsumed dividend bits (MSB first) and collects quotient bits.
// Ports:
//   i_div   1  select divide step (else multiply step)
//   i_acc   W  high half: partial product / partial remainder
//   i_x     W  low half : multiplier / dividend-and-quotient
//   i_opnd  W  multiplicand / divisor
//   o_acc   W  next high half
//   o_x     W  next low half
// -----------------------------------------------------------------------------
module mdu_step
  import mdu_iter_pkg::*;
#(
  parameter int W = MDU_W
)
(
  input  logic         i_div,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_opnd,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_x
);

  logic [W:0]   w_sum;    // acc + multiplicand, carry kept for the shift
  logic [W:0]   w_shift;  // remainder shifted left with next dividend bit
  logic [W-1:0] w_diff;   // trial remainder after subtracting the divisor
  logic         w_ge;     // trial subtraction succeeds -> quotient bit 1

  assign w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
  assign w_shift = {i_acc, i_x[W-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opnd});
  // Only the low W bits matter: when w_ge holds the true difference is < divisor.
  assign w_diff  = w_shift[W-1:0] - i_opnd;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_acc = i_acc;
    o_x   = i_x;
    if (i_div) begin
      o_acc = w_ge ? w_diff : w_shift[W-1:0];
      o_x   = {i_x[W-2:0], w_ge};
    end else if (i_x[0]) begin
      {o_acc, o_x} = {w_sum, i_x[W-1:1]};
    end else begin
      {o_acc, o_x} = {1'b0, i_acc, i_x[W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative MIPS-style multiply/divide unit with architectural HI/LO.
// Sits downstream of the register file (a <- qa, b <- qb); hi/lo feed the
// MFHI/MFLO writeback mux. Each operation runs IDLE -> CALC (32 cycles) ->
// FIX (1 cycle) -> IDLE; done pulses the cycle after FIX with hi/lo valid.
// Signed ops iterate on magnitudes and fix the signs in FIX.
// Ports:
//   clk            rising-edge clock
//   clr            synchronous active-high reset / abort
//   start          request an operation (sampled only in IDLE)
//   op[1:0]        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b [W]       rs / rt operands
//   hi_we, lo_we   MTHI / MTLO strobes (IDLE and start=0 only)
//   wd [W]         MTHI / MTLO data
//   busy           state != IDLE
//   done           one-cycle commit pulse
//   dz             divide-by-zero, valid with done
//   hi, lo [W]     architectural HI / LO
// -----------------------------------------------------------------------------
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int W = MDU_W
)
(
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  mdu_state_e           r_state, w_next_state;
  logic [MDU_CNT_W-1:0] r_cnt;
  mdu_op_e              r_op;
  logic [W-1:0]         r_acc, r_x, r_opnd;
  logic                 r_neg_res;   // quotient / product must be negated
  logic                 r_neg_rem;   // remainder takes the dividend's sign
  logic                 r_dz_pend;   // divide with b == 0
  logic [W-1:0]         r_hi, r_lo;
  logic                 r_done, r_dz;

  mdu_op_e              w_op;
  logic                 w_idle, w_take, w_mt_ok, w_is_div;
  logic                 w_a_neg, w_b_neg;
  logic [W-1:0]         w_a_mag, w_b_mag;
  logic [W-1:0]         w_step_acc, w_step_x;
  logic [2*W-1:0]       w_prod, w_prod_fix;
  logic [W-1:0]         w_quo, w_rem;

  assign w_op    = mdu_op_e'(op);
  assign w_idle  = (r_state == ST_IDLE);
  assign w_take  = w_idle & start;
  // start wins over MTHI/MTLO in IDLE; both are dropped while busy.
  assign w_mt_ok = w_idle & ~start;

  assign w_a_neg = op_is_signed(w_op) & a[W-1];
  assign w_b_neg = op_is_signed(w_op) & b[W-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  assign w_is_div = op_is_div(r_op);

  mdu_step #(.W(W)) u_step (
    .i_div  (w_is_div),
    .i_acc  (r_acc),
    .i_x    (r_x),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_x    (w_step_x)
  );

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next_state = ST_CALC;
      ST_CALC: if (r_cnt == MDU_CNT_W'(MDU_ITERS - 1)) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr)                    r_cnt <= '0;
    else if (w_take)            r_cnt <= '0;
    else if (r_state == ST_CALC) r_cnt <= r_cnt + MDU_CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // NOTE: these registers carry no reset; they are fully reloaded on every
  // accepted start and nothing observes them while IDLE.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_op      <= w_op;
      r_acc     <= '0;
      r_x       <= w_a_mag;
      r_opnd    <= w_b_mag;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_dz_pend <= op_is_div(w_op) && (b == '0);
    end else if (r_state == ST_CALC) begin
      r_acc <= w_step_acc;
      r_x   <= w_step_x;
    end
  end

  // Sign correction. A zero divisor leaves |a| in the remainder, so the
  // signed remainder fix already yields hi = a; only the quotient is forced.
  assign w_prod     = {r_acc, r_x};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo      = r_dz_pend ? '1 : (r_neg_res ? -r_x : r_x);
  assign w_rem      = r_neg_rem ? -r_acc : r_acc;

  // ---------------------------------------------------------------------------
  // Architectural HI/LO and completion flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_FIX) begin
      if (w_is_div) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        {r_hi, r_lo} <= w_prod_fix;
      end
    end else if (w_mt_ok) begin
      if (hi_we) r_hi <= wd;
      if (lo_we) r_lo <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      r_dz   <= (r_state == ST_FIX) && w_is_div && r_dz_pend;
    end
  end

  assign busy = ~w_idle;
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
// Self-checking bench for mdu_iter. A behavioural model computes results with
// plain 64-bit arithmetic and tracks HI/LO, busy and done per clock edge; a
// compare process checks the DUT against it on every falling edge. Directed
// vectors add hand-computed literal expectations.
// Inputs are driven on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  localparam int W   = 32;
  localparam int LAT = 33;  // edges from the start edge to the committing edge

  logic         clk = 1'b0;
  logic         clr, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.W(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {dz, hi, lo} from ordinary integer arithmetic.
  function automatic logic [2*W:0] ref_result(input logic [1:0] f_op,
                                              input logic [W-1:0] fa,
                                              input logic [W-1:0] fb);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    if (f_op == 2'b00) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (f_op == 2'b01) begin
      p = {32'd0, fa} * {32'd0, fb};
      return {1'b0, p};
    end
    if (fb == '0) return {1'b1, fa, 32'hFFFF_FFFF};
    if (f_op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    return {1'b0, fa % fb, fa / fb};
  endfunction

  // Behavioural model: a countdown to the committing edge plus HI/LO.
  int           m_left = 0;
  logic         m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi, m_lo;
  logic [2*W:0] m_pend;

  always @(posedge clk) begin
    if (clr) begin
      m_left = 0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = 1'b0;
      if (m_left == 0) begin
        {m_dz, m_hi, m_lo} = m_pend;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = ref_result(op, a, b);
        m_left = LAT;
      end else begin
        if (hi_we) m_hi = wd;
        if (lo_we) m_lo = wd;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", busy, m_left != 0);
      check("model_done", done, m_done);
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
      if (m_done) check("model_dz", dz, m_dz);
    end
  end

  // Issue one operation and wait (bounded) for its done pulse. edges counts
  // clock edges from the start edge (edge 1) to the edge raising done.
  task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, output int edges, output int busy_cyc);
    op = t_op; a = ta; b = tb; start = 1'b1;
    edges = 0; busy_cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      edges++;
      if (busy) busy_cyc++;
    end while (!done && edges < 100);
    if (!done) check("op_timeout", done, 1'b1);
  endtask

  int edges, bcyc, pulses;

  initial begin
    clr = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wd = '0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    // MULTU max*max, latency and busy window
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bcyc);
    check("multu_edges", edges, 34);
    check("multu_busy_cycles", bcyc, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_dz", dz, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Signed multiply and signed divide
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, edges, bcyc);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, edges, bcyc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero, then the overflow case
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, edges, bcyc);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'h0000_0064);
    check("dz_flag", dz, 1);
    @(negedge clk);
    check("dz_done_drop", done, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, edges, bcyc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);
    check("ovf_dz", dz, 0);

    // Start re-asserted mid-operation with different operands is ignored
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b10; a = 32'hFFFF_FFFF; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_hi", hi, 32'h0000_0000);
    check("ignore_lo", lo, 32'h0000_000C);

    // clr aborts a divide in flight
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(2'b11, 32'd1000, 32'd7, edges, bcyc);
    check("fresh_edges", edges, 34);
    check("fresh_lo", lo, 32'd142);
    check("fresh_hi", hi, 32'd6);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wd = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo_kept", lo, 32'd142);
    lo_we = 1'b1; wd = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'h1234_5678);

    // Strobes on the start edge and while busy are dropped
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_hi_hold", hi, 32'h1234_5678);
    check("busy_lo_hold", lo, 32'hCAFE_F00D);
    hi_we = 1'b0; lo_we = 1'b0;
    edges = 0;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("strobe_op_done", done, 1);
    check("strobe_op_hi", hi, 32'd0);
    check("strobe_op_lo", lo, 32'd6);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
